// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the handshaked data memory (dmem_ctrl).
//
// Contents:
//   F3_B/F3_H/F3_W/F3_BU/F3_HU  RV32 load/store size codes (funct3)
//   state_e                     controller FSM states (IDLE, BUSY, RESP)
//   f3_legal()                  true for the five defined size codes
//   byte_en()                   per-byte write enable from size and lane offset
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // sz is funct3[1:0]: 00 byte, 01 halfword, 10 word. off is expected to be
    // already aligned to the access size.
    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << {off[1], 1'b0};
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// dmem_load_ext -- combinational load lane select and sign/zero extension.
//
// Ports:
//   word_i    32-bit word read from the array
//   off_i     byte offset of the access inside the word (already size-aligned)
//   funct3_i  RV32 size code; undefined codes produce 0
//   data_o    selected lane shifted to bit 0 and extended to 32 bits
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = word_i >> {off_i, 3'b000};

    always_comb begin
        data_o = 32'd0;
        case (funct3_i)
            F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
            // Word accesses always arrive with off_i == 0, so shifted == word_i.
            F3_W:    data_o = shifted;
            F3_BU:   data_o = {24'd0, shifted[7:0]};
            F3_HU:   data_o = {16'd0, shifted[15:0]};
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- handshaked byte/halfword/word data memory with programmable latency.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   LATENCY      cycles from request acceptance to response (1..15)
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   req_valid/req_ready              request handshake
//   req_we, req_funct3, req_addr, req_wdata   request fields (wdata LSB-aligned)
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata    extended load data (0 for stores and faulted accesses)
//   rsp_err      out-of-range, undefined funct3 or (optionally) misaligned access
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   -> misaligned H/HU/W accesses fault (no store, rdata 0)
//   undefined -> misaligned low address bits are cleared and the access proceeds
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [31:0] mem [DEPTH_WORDS];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Latched request
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    // Registered response
    logic [31:0] rdata_q;
    logic        err_q;

    // Decode of the latched request
    logic             out_of_range;
    logic             misaligned;
    logic             acc_err;
    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      wdata_sh;
    logic [31:0]      rd_word;
    logic [31:0]      ld_data;
    logic             exec;
    logic             accept;

    assign accept = req_valid && req_ready;
    assign exec   = (state_q == BUSY) && (cnt_q == 4'd0);

    assign out_of_range = |addr_q[31:2+IDX_W];
    assign idx          = addr_q[2+IDX_W-1:2];

    assign misaligned = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                        ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));

    // Lane offset with the size-illegal low bits cleared. In trap mode a
    // misaligned access faults before the offset is ever used.
    always_comb begin
        off = addr_q[1:0];
        case (f3_q[1:0])
            2'b01:   off = {addr_q[1], 1'b0};
            2'b10:   off = 2'b00;
            default: off = addr_q[1:0];
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign acc_err = out_of_range || !f3_legal(f3_q) || misaligned;
`else
    assign acc_err = out_of_range || !f3_legal(f3_q);
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
`endif

    assign be       = byte_en(f3_q[1:0], off);
    assign wdata_sh = wdata_q << {off, 3'b000};
    assign rd_word  = mem[idx];

    dmem_load_ext u_load_ext (
        .word_i   (rd_word),
        .off_i    (off),
        .funct3_i (f3_q),
        .data_o   (ld_data)
    );

    // req_ready is masked by rst so the core never sees a handshake that the
    // reset is about to discard.
    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (exec) begin
                err_q   <= acc_err;
                rdata_q <= (!we_q && !acc_err) ? ld_data : 32'd0;
            end
        end
    end

    // Request fields are plain data and need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // A reset coinciding with the execute edge drops the store.
    always_ff @(posedge clk) begin
        if (!rst && exec && we_q && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

endmodule
